// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: state encoding, status magic and helpers shared by the SPI register controller files
package spi_reg_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ_TURN, READ, DISCARD} state_e;
  localparam logic [3:0] STATUS_MAGIC = 4'hA;
  function automatic int cmd_write_bit(input int word_bits);
    return word_bits - 1;
  endfunction
  function automatic logic [7:0] status_word(input logic err);
    return {STATUS_MAGIC, 3'b000, err};
  endfunction
endpackage

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: NUM_REGS x WORD_BITS register file with one write port, one async read port and flat export
//   clk, rst_n        : clock, async active-low reset (all regs -> RESET_VALUE)
//   we_i/widx_i/wdata_i : write enable, index, data
//   ridx_i/rdata_o    : combinational read port
//   regs_flat_o       : reg i at [i*WORD_BITS +: WORD_BITS]
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int NUM_REGS = 16,
  parameter logic [WORD_BITS-1:0] RESET_VALUE = '0,
  localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we_i,
  input  logic [ADDR_BITS-1:0]          widx_i,
  input  logic [WORD_BITS-1:0]          wdata_i,
  input  logic [ADDR_BITS-1:0]          ridx_i,
  output logic [WORD_BITS-1:0]          rdata_o,
  output logic [NUM_REGS*WORD_BITS-1:0] regs_flat_o
);
  logic [WORD_BITS-1:0] regs_q [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VALUE;
    else if (we_i) regs_q[widx_i] <= wdata_i;
  assign rdata_o = regs_q[ridx_i];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat_o[i*WORD_BITS +: WORD_BITS] = regs_q[i];
  end
endmodule

// File: rtl/spi_reg_controller.sv
// spi_reg_controller: frame-level SPI register controller (command/address/burst decode, status turnaround)
//   clk, rst_n             : system clock, async active-low reset
//   cs_i                   : raw chip select (1 = deselected), synchronized internally
//   word_ready_i           : one-cycle pulse from the shifter, data_word_received_i valid with it
//   data_word_to_send_o    : next word the shifter loads
//   regs_flat_o            : register bank export
//   wr_strobe_o/wr_index_o : one-cycle pulse and index after an SPI register write
//   frame_error_o          : sticky out-of-range command flag
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int NUM_REGS = 16,
  parameter logic [WORD_BITS-1:0] RESET_VALUE = '0,
  localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs_i,
  input  logic                          word_ready_i,
  input  logic [WORD_BITS-1:0]          data_word_received_i,
  output logic [WORD_BITS-1:0]          data_word_to_send_o,
  output logic [NUM_REGS*WORD_BITS-1:0] regs_flat_o,
  output logic                          wr_strobe_o,
  output logic [ADDR_BITS-1:0]          wr_index_o,
  output logic                          frame_error_o
);
  localparam int WB = cmd_write_bit(WORD_BITS);
  // command bits between the address field and the write bit must be zero
  localparam logic [WORD_BITS-1:0] MID_MASK =
    {1'b0, {(WORD_BITS-1){1'b1}}} & ~{{(WORD_BITS-ADDR_BITS){1'b0}}, {ADDR_BITS{1'b1}}};
  state_e state_q, state_d;
  logic cs_meta_q, cs_s_q, armed_q;
  logic [1:0] vld_q;
  logic [ADDR_BITS-1:0] addr_q, addr_d, wr_index_q, wr_index_d, cmd_addr, ridx;
  logic [WORD_BITS-1:0] rd_q, rd_d, rdata;
  logic err_q, err_d, wr_strobe_q, wr_strobe_d;
  logic acc, cmd_oor, cmd_wr, we;
  assign acc = word_ready_i && !cs_s_q && armed_q;
  assign cmd_addr = data_word_received_i[ADDR_BITS-1:0];
  assign cmd_oor = |(data_word_received_i & MID_MASK);
  assign cmd_wr = data_word_received_i[WB];
  assign we = acc && state_q == WRITE;
  assign ridx = state_q == IDLE ? cmd_addr : addr_q + ADDR_BITS'(1);
  spi_reg_bank #(
    .WORD_BITS(WORD_BITS),
    .NUM_REGS(NUM_REGS),
    .RESET_VALUE(RESET_VALUE)
  ) u_bank (
    .clk(clk),
    .rst_n(rst_n),
    .we_i(we),
    .widx_i(addr_q),
    .wdata_i(data_word_received_i),
    .ridx_i(ridx),
    .rdata_o(rdata),
    .regs_flat_o(regs_flat_o)
  );
  // the sync flops reset to 1, so vld_q marks when cs_s_q reflects a real sample;
  // armed_q then requires a genuine deselect before the first frame after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {cs_s_q, cs_meta_q} <= 2'b11;
      vld_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      {cs_s_q, cs_meta_q} <= {cs_meta_q, cs_i};
      vld_q <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (cs_s_q & vld_q[1]);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (cs_s_q) state_d = IDLE;
    else if (acc && state_q == IDLE) state_d = cmd_oor ? DISCARD : cmd_wr ? WRITE : READ_TURN;
    else if (acc && state_q == READ_TURN) state_d = READ;
  end
  always_comb begin
    addr_d = addr_q;
    rd_d = rd_q;
    err_d = err_q;
    wr_strobe_d = we;
    wr_index_d = we ? addr_q : wr_index_q;
    if (acc) begin
      addr_d = state_q == IDLE ? cmd_addr : addr_q + ADDR_BITS'(1);
      rd_d = rdata;
      err_d = (state_q == IDLE && cmd_oor) | (err_q & (state_q != READ_TURN));
    end
    data_word_to_send_o = (cs_s_q || state_q == IDLE) ? WORD_BITS'(status_word(err_q)) :
                          (state_q == READ_TURN || state_q == READ) ? rd_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      addr_q <= addr_d;
      rd_q <= rd_d;
      err_q <= err_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q <= wr_index_d;
    end
  assign wr_strobe_o = wr_strobe_q;
  assign wr_index_o = wr_index_q;
  assign frame_error_o = err_q;
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: table-driven, hand-sequenced and randomized checks of spi_reg_controller
module tb_spi_reg_controller;
  localparam int W = 8, N = 16, GAP = 3 * W;
  logic clk = 0, rst_n = 0, cs = 1, wr = 0;
  logic [W-1:0] din = '0, dws;
  logic [N*W-1:0] regs_flat;
  logic wr_strobe, frame_error;
  logic [3:0] wr_index;
  int tests = 0, fails = 0;
  logic [7:0] mregs [N];
  logic merr;
  int wrq[$];
  typedef struct packed {
    logic [0:4][7:0] w;
    logic [0:4][7:0] m;
    logic [3:0] n;
    logic err;
    logic [3:0] nwr;
    logic [3:0] wi0;
  } vec_t;
  vec_t tbl [6];
  always #5 clk = ~clk;
  spi_reg_controller #(.WORD_BITS(W), .NUM_REGS(N), .RESET_VALUE('0)) dut (
    .clk(clk), .rst_n(rst_n), .cs_i(cs), .word_ready_i(wr), .data_word_received_i(din),
    .data_word_to_send_o(dws), .regs_flat_o(regs_flat), .wr_strobe_o(wr_strobe),
    .wr_index_o(wr_index), .frame_error_o(frame_error)
  );
  always @(negedge clk) if (wr_strobe) wrq.push_back(int'(wr_index));
  function automatic logic [7:0] st(input logic e);
    return {4'hA, 3'b000, e};
  endfunction
  function automatic logic [N*W-1:0] mflat();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = mregs[i];
    return f;
  endfunction
  task automatic chk(input string nm, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic pulse(input logic [7:0] d);
    wr = 1;
    din = d;
    @(negedge clk);
    wr = 0;
  endtask
  // acts as master plus shifter: each word shifts out what was loaded at the previous word_ready
  task automatic frame(input logic [7:0] q[$], output logic [7:0] got[$]);
    logic [7:0] loaded;
    got = {};
    wrq = {};
    @(negedge clk);
    loaded = dws;
    cs = 0;
    repeat (4) @(negedge clk);
    foreach (q[i]) begin
      repeat (GAP) @(negedge clk);
      got.push_back(loaded);
      loaded = dws;
      pulse(q[i]);
    end
    repeat (GAP) @(negedge clk);
    cs = 1;
    repeat (4) @(negedge clk);
  endtask
  // frame-level reference: MISO = status, status, then data (reads) or zeros; writes applied in order
  task automatic model_frame(input logic [7:0] q[$], output logic [7:0] em[$], output int ew[$]);
    logic [7:0] s;
    int a;
    logic oor, w;
    em = {};
    ew = {};
    if (q.size() == 0) return;
    s = st(merr);
    a = int'(q[0][3:0]);
    oor = q[0][6:4] != 3'b000;
    w = q[0][7];
    for (int k = 0; k < q.size(); k++)
      em.push_back(k < 2 ? s : (oor || w) ? 8'h00 : mregs[(a + k - 2) % N]);
    if (oor) merr = 1;
    else if (w) for (int k = 1; k < q.size(); k++) begin
      mregs[(a + k - 1) % N] = q[k];
      ew.push_back((a + k - 1) % N);
    end
    else if (q.size() >= 2) merr = 0;
  endtask
  initial begin
    logic [7:0] q[$], got[$], em[$];
    int ew[$];
    logic [N*W-1:0] exp;
    tbl[0] = '{w: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, m: {8'hA0, 8'hA0, 8'h00, 8'h00, 8'h00}, n: 4, err: 0, nwr: 0, wi0: 0};
    tbl[1] = '{w: {8'h83, 8'h11, 8'h22, 8'h33, 8'h00}, m: {8'hA0, 8'hA0, 8'h00, 8'h00, 8'h00}, n: 4, err: 0, nwr: 3, wi0: 3};
    tbl[2] = '{w: {8'h8F, 8'hAA, 8'hBB, 8'h00, 8'h00}, m: {8'hA0, 8'hA0, 8'h00, 8'h00, 8'h00}, n: 3, err: 0, nwr: 2, wi0: 15};
    tbl[3] = '{w: {8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}, m: {8'hA0, 8'hA0, 8'hAA, 8'hBB, 8'h00}, n: 4, err: 0, nwr: 0, wi0: 0};
    tbl[4] = '{w: {8'h20, 8'h55, 8'h66, 8'h00, 8'h00}, m: {8'hA0, 8'hA0, 8'h00, 8'h00, 8'h00}, n: 3, err: 1, nwr: 0, wi0: 0};
    tbl[5] = '{w: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, m: {8'hA1, 8'hA1, 8'hBB, 8'h00, 8'h00}, n: 3, err: 0, nwr: 0, wi0: 0};
    for (int i = 0; i < N; i++) mregs[i] = 8'h00;
    merr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("reset dws", dws, 8'hA0);
    chk("reset regs", regs_flat, '0);
    chk("reset err", frame_error, 0);
    chk("reset strobe", wr_strobe, 0);
    chk("reset windex", wr_index, 0);
    for (int i = 0; i < 6; i++) begin
      q = {};
      for (int j = 0; j < int'(tbl[i].n); j++) q.push_back(tbl[i].w[j]);
      frame(q, got);
      model_frame(q, em, ew);
      for (int j = 0; j < int'(tbl[i].n); j++) chk($sformatf("tbl%0d miso%0d", i, j), got[j], tbl[i].m[j]);
      chk($sformatf("tbl%0d err", i), frame_error, tbl[i].err);
      chk($sformatf("tbl%0d nwr", i), wrq.size(), tbl[i].nwr);
      foreach (wrq[k]) chk($sformatf("tbl%0d widx%0d", i, k), wrq[k], (int'(tbl[i].wi0) + k) % N);
    end
    exp = '0;
    exp[3*W +: W] = 8'h11;
    exp[4*W +: W] = 8'h22;
    exp[5*W +: W] = 8'h33;
    exp[15*W +: W] = 8'hAA;
    exp[0 +: W] = 8'hBB;
    chk("tbl regs", regs_flat, exp);
    // cs released mid-word: the word_ready that coincides with cs_s=1 must be dropped
    wrq = {};
    cs = 0;
    repeat (4) @(negedge clk);
    pulse(8'h87);
    repeat (GAP) @(negedge clk);
    pulse(8'h5C);
    repeat (GAP) @(negedge clk);
    cs = 1;
    repeat (2) @(negedge clk);
    pulse(8'hE7);
    mregs[7] = 8'h5C;
    chk("abort dws", dws, 8'hA0);
    repeat (3) @(negedge clk);
    chk("abort nwr", wrq.size(), 1);
    chk("abort regs", regs_flat, mflat());
    chk("abort idle dws", dws, 8'hA0);
    // reset mid write burst with a pending error; cs stays low across reset
    q = {8'h30, 8'h01};
    frame(q, got);
    model_frame(q, em, ew);
    chk("pre-reset err", frame_error, 1);
    cs = 0;
    repeat (4) @(negedge clk);
    pulse(8'h81);
    repeat (GAP) @(negedge clk);
    pulse(8'h12);
    repeat (GAP / 2) @(negedge clk);
    rst_n = 0;
    wrq = {};
    #1;
    chk("midrst regs", regs_flat, '0);
    chk("midrst err", frame_error, 0);
    chk("midrst dws", dws, 8'hA0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    pulse(8'h83);
    repeat (GAP) @(negedge clk);
    pulse(8'h44);
    repeat (GAP) @(negedge clk);
    chk("postrst nwr", wrq.size(), 0);
    chk("postrst regs", regs_flat, '0);
    cs = 1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) mregs[i] = 8'h00;
    merr = 0;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] cmd;
      int len;
      cmd = 8'($urandom);
      cmd[6:4] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      len = $urandom_range(1, 5);
      q = {cmd};
      for (int k = 1; k < len; k++) q.push_back(8'($urandom));
      frame(q, got);
      model_frame(q, em, ew);
      foreach (em[k]) chk($sformatf("rnd%0d miso%0d", f, k), got[k], em[k]);
      chk($sformatf("rnd%0d regs", f), regs_flat, mflat());
      chk($sformatf("rnd%0d err", f), frame_error, merr);
      chk($sformatf("rnd%0d dws", f), dws, st(merr));
      chk($sformatf("rnd%0d nwr", f), wrq.size(), ew.size());
      for (int k = 0; k < wrq.size() && k < ew.size(); k++) chk($sformatf("rnd%0d widx%0d", f, k), wrq[k], ew[k]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_reg_controller.md
Name: spi_reg_controller

Overview:
- Frame-level controller behind the byte-wide SPI secondary shifter. Clocked on the system clk domain.
- Consumes word_ready pulses and received words; decodes command/address/burst frames.
- Drives the next word to send and owns a NUM_REGS x WORD_BITS configuration register bank, exported to the motion/step-generator logic.
- Adds frame awareness (cs), turnaround/status byte, address auto-increment and error flagging, which the shifter lacks.

Parameters:
- WORD_BITS, 8, SPI word width; must equal the shifter's WORD_BITS.
- NUM_REGS, 16, register count; power of two, 2 <= NUM_REGS <= 2**(WORD_BITS-1).
- RESET_VALUE, 0, reset value of every register (WORD_BITS wide).
- ADDR_BITS, $clog2(NUM_REGS), localparam, register index width.

Ports:
- clk  in  1  system clock (same clock as the shifter).
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  raw SPI chip select, asynchronous; 1 = deselected, 0 = frame active.
- word_ready  in  1  one-cycle pulse from the shifter: a word is complete.
- data_word_received  in  WORD_BITS  word from the shifter, valid while word_ready = 1.
- data_word_to_send  out  WORD_BITS  word the shifter loads on the next word_ready or while cs = 1.
- regs_flat  out  NUM_REGS*WORD_BITS  register bank; reg i at bits [i*WORD_BITS +: WORD_BITS].
- wr_strobe  out  1  one-cycle pulse when a register is written over SPI.
- wr_index  out  ADDR_BITS  index written; valid with wr_strobe.
- frame_error  out  1  sticky error flag (also mirrored in the status word).

Behaviour:
- Reset (rst_n = 0, async):
  - state = IDLE.
  - All registers = RESET_VALUE.
  - data_word_to_send = STATUS.
  - wr_strobe = 0, wr_index = 0, frame_error = 0, addr = 0.
  - cs synchronizer flops = 1.
- cs passes through a 2-flop synchronizer; cs_s is the synchronized value.
- cs_s = 1 has priority over everything:
  - state = IDLE, data_word_to_send = STATUS.
  - A word_ready in the same cycle is discarded: no write, no error update.
- STATUS word = {4'hA, zeros, frame_error} in the low bits, zero-extended to WORD_BITS.
- Command word (first word of a frame): bit WORD_BITS-1 = 1 for write, 0 for read; bits [ADDR_BITS-1:0] = start address. Bits between ADDR_BITS and WORD_BITS-2 must be 0, otherwise the address is out of range.
- States, transitions on word_ready with cs_s = 0:
  - IDLE: latch addr.
    - Out of range -> set frame_error, go to DISCARD.
    - Write bit -> WRITE.
    - Otherwise -> READ_TURN; data_word_to_send = regs[addr] on the next cycle.
  - WRITE: regs[addr] <= received word. Pulse wr_strobe with wr_index = addr one cycle later. addr <= addr + 1 mod NUM_REGS. data_word_to_send = 0. Stay in WRITE.
  - READ_TURN: the word just clocked out was STATUS. addr <= addr + 1 mod NUM_REGS. data_word_to_send <= regs[addr + 1]. Clear frame_error (it has been reported). Go to READ.
  - READ: data_word_to_send <= regs[addr + 1]. addr++ with wrap. Stay in READ.
  - DISCARD: ignore received words; data_word_to_send = 0; exit only on cs_s = 1.
- Read latency on the MISO side:
  - Word 0 shifts out the value loaded before the frame (STATUS).
  - Word 1 shifts out what data_word_to_send held at command completion (also STATUS, the turnaround word).
  - Word k >= 2 returns regs[start + k - 2], with wrap.
- data_word_to_send must be stable at least 1 clk before each word_ready. One register update per word_ready is sufficient because words are >= WORD_BITS*3 clks apart.
- Write burst wraps from NUM_REGS-1 to 0.
- A frame with only a command word (cs released) performs no access.
- frame_error also sets on out-of-range commands. It clears only in READ_TURN, or on reset.
- rst_n asserted mid-frame: immediate return to reset values. The next frame needs a fresh cs cycle; the controller stays IDLE until cs_s has been 1 at least once.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum (IDLE, WRITE, READ_TURN, READ, DISCARD),
  - STATUS_MAGIC = 4'hA,
  - CMD_WRITE_BIT index function of WORD_BITS,
  - the status-word build function.
- One natural sub-module: spi_reg_bank. It holds the registers, write port (en, index, data), async-reset to RESET_VALUE, combinational read port and the flat export. The controller FSM stays in spi_reg_controller.

Test Plan:
- Reset, then a frame cs=0 sending 8'h00 followed by 3 words -> MISO words are A0, A0, 00, 00 (regs = RESET_VALUE = 0); no wr_strobe.
- Write frame 8'h83, 11, 22, 33 -> regs[3..5] = 11, 22, 33; wr_strobe pulses 3x with wr_index 3, 4, 5.
- Write burst 8'h8F, AA, BB (NUM_REGS=16) -> regs[15] = AA, regs[0] = BB (wrap); then read 8'h0F + 3 dummy words -> MISO A0, A0, AA, BB.
- Command 8'h20 (addr out of range) + 2 words -> no writes, MISO zeros after word 1, frame_error = 1. Next read frame returns status A1 on word 1; frame_error = 0 afterwards.
- cs deasserted after 4 of 8 bits of a write data word, coincident with a word_ready -> no register change, state IDLE, data_word_to_send = A0.
- rst_n pulsed low mid-burst write -> all regs 0 immediately, frame_error 0, no wr_strobe after release until a new frame.
